// File: rtl/me_frame_scheduler.sv
// Raster-order macroblock walker that drives the hexagon ME core and writes
// packed MV results. Define ME_SAD_ACC_EN for the saturating frame SAD total.
module me_frame_scheduler #(
  parameter int WIDTH  = 352,
  parameter int HEIGHT = 240,
  parameter int AW     = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_go,
  input  logic [31:0]   cur_base,
  input  logic [31:0]   ref_base,
  output logic          me_start,
  output logic [31:0]   me_frame_addr,
  output logic [31:0]   me_ref_addr,
  output logic [31:0]   me_mb_x,
  output logic [31:0]   me_mb_y,
  input  logic [5:0]    me_mv_x,
  input  logic [5:0]    me_mv_y,
  input  logic [15:0]   me_sad,
  input  logic          me_done,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_addr,
  output logic [31:0]   res_data,
  output logic          busy,
  output logic          frame_done,
  output logic [31:0]   frame_sad
);
  localparam int MBS_X = WIDTH / 16;
  localparam int MBS_Y = HEIGHT / 16;
  localparam int CW = (MBS_X > 1) ? $clog2(MBS_X) : 1;
  localparam int RW = (MBS_Y > 1) ? $clog2(MBS_Y) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WRITE,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   cur_q, cur_d;
  logic [31:0]   ref_q, ref_d;
  logic          start_q, start_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          fdone_q, fdone_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          last_mb;
  logic          acc_clr;
  logic          acc_add;

  assign last_mb = (col_q == CW'(MBS_X - 1)) &&
                   (row_q == RW'(MBS_Y - 1));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    ref_d   = ref_q;
    start_d = start_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    fdone_d = 1'b0;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_go) begin
          cur_d   = cur_base;
          ref_d   = ref_base;
          col_d   = '0;
          row_d   = '0;
          idx_d   = '0;
          start_d = 1'b1;
          acc_clr = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (me_done) begin
          data_d  = {4'b0, me_mv_x, me_mv_y, me_sad};
          addr_d  = idx_q;
          valid_d = 1'b1;
          acc_add = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (res_ready) begin
          valid_d = 1'b0;
          start_d = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // core must have dropped done before the next start is raised
        if (!me_done) begin
          if (last_mb) begin
            fdone_d = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            start_d = 1'b1;
            state_d = S_ISSUE;
            if (col_q == CW'(MBS_X - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      ref_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      ref_q   <= ref_d;
      start_q <= start_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign me_start      = start_q;
  assign me_frame_addr = cur_q;
  assign me_ref_addr   = ref_q;
  assign me_mb_x       = 32'(col_q) << 4;
  assign me_mb_y       = 32'(row_q) << 4;
  assign res_valid     = valid_q;
  assign res_addr      = addr_q;
  assign res_data      = data_q;
  assign busy          = busy_q;
  assign frame_done    = fdone_q;

`ifdef ME_SAD_ACC_EN
  logic [31:0] sad_q;
  logic [32:0] sad_sum;

  assign sad_sum = {1'b0, sad_q} + 33'(me_sad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad_q <= '0;
    end else if (acc_clr) begin
      sad_q <= '0;
    end else if (acc_add) begin
      sad_q <= sad_sum[32] ? '1 : sad_sum[31:0];
    end
  end

  assign frame_sad = sad_q;
`else
  logic unused_acc;
  assign unused_acc = acc_clr | acc_add;
  assign frame_sad  = '0;
`endif

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Scoreboard bench for me_frame_scheduler with a stub ME core and
// a randomized result buffer.
module tb_me_frame_scheduler;
  localparam int NMB = 330;
  localparam int MX  = 22;

  logic        clk;
  logic        rst_n;
  logic        frame_go;
  logic [31:0] cur_base, ref_base;
  logic        me_start;
  logic [31:0] me_frame_addr, me_ref_addr, me_mb_x, me_mb_y;
  logic [5:0]  me_mv_x, me_mv_y;
  logic [15:0] me_sad;
  logic        me_done;
  logic        res_valid, res_ready;
  logic [8:0]  res_addr;
  logic [31:0] res_data;
  logic        busy, frame_done;
  logic [31:0] frame_sad;

  me_frame_scheduler dut (
    .clk(clk), .rst_n(rst_n), .frame_go(frame_go),
    .cur_base(cur_base), .ref_base(ref_base),
    .me_start(me_start), .me_frame_addr(me_frame_addr),
    .me_ref_addr(me_ref_addr), .me_mb_x(me_mb_x), .me_mb_y(me_mb_y),
    .me_mv_x(me_mv_x), .me_mv_y(me_mv_y), .me_sad(me_sad),
    .me_done(me_done), .res_valid(res_valid), .res_ready(res_ready),
    .res_addr(res_addr), .res_data(res_data), .busy(busy),
    .frame_done(frame_done), .frame_sad(frame_sad)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // reference model state
  int          mvx[NMB], mvy[NMB], sads[NMB], dlys[NMB];
  int          hold_cyc;
  bit          rnd_ready;
  int          stall_left;
  logic [31:0] exp_cur, exp_ref, exp_fsad;
  int          exp_addr[$];
  logic [31:0] exp_data[$];

  // shared progress counters
  int wr_cnt, edge_cnt, fd_cnt, st_k;

  function automatic logic [31:0] pack(input int mx, input int my,
                                       input int s);
    return 32'(((mx & 63) << 22) | ((my & 63) << 16) | (s & 16'hFFFF));
  endfunction

  task automatic setup_frame(input int mode, input int d, input int h,
                             input bit rr);
    longint sum;
    sum = 0;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < NMB; i++) begin
      if (mode == 1) begin
        mvx[i] = -3; mvy[i] = 2; sads[i] = 16'h0100;
      end else begin
        mvx[i]  = int'($urandom_range(0, 63)) - 32;
        mvy[i]  = int'($urandom_range(0, 63)) - 32;
        sads[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF
                                              : int'($urandom_range(0, 65535));
      end
      dlys[i] = (d != 0) ? d : int'($urandom_range(1, 6));
      exp_addr.push_back(i);
      exp_data.push_back(pack(mvx[i], mvy[i], sads[i]));
      sum += sads[i];
    end
`ifdef ME_SAD_ACC_EN
    exp_fsad = (sum > 64'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(sum);
`else
    exp_fsad = 32'h0;
`endif
    hold_cyc  = h;
    rnd_ready = rr;
    st_k      = 0;
    wr_cnt    = 0;
    edge_cnt  = 0;
    exp_cur   = $urandom;
    exp_ref   = $urandom;
  endtask

  task automatic go();
    @(posedge clk); #1;
    cur_base = exp_cur;
    ref_base = exp_ref;
    frame_go = 1;
    @(posedge clk); #1;
    frame_go = 0;
    cur_base = ~exp_cur;
    ref_base = ~exp_ref;
  endtask

  task automatic wait_fd(input int budget);
    int f0;
    int n;
    f0 = fd_cnt;
    n = 0;
    while (fd_cnt == f0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("frame_done_seen", 64'(fd_cnt != f0), 64'd1);
  endtask

  task automatic wait_wr(input int target, input int budget);
    int n;
    n = 0;
    while (wr_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("write_progress", 64'(wr_cnt >= target), 64'd1);
  endtask

  task automatic idle_check();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_start", 64'(me_start), 64'd0);
    chk("idle_valid", 64'(res_valid), 64'd0);
    chk("idle_frame_sad", 64'(frame_sad), 64'(exp_fsad));
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_start"}, 64'(me_start), 64'd0);
    chk({tag, "_faddr"}, 64'(me_frame_addr), 64'd0);
    chk({tag, "_raddr"}, 64'(me_ref_addr), 64'd0);
    chk({tag, "_mbxy"}, {me_mb_x, me_mb_y}, 64'd0);
    chk({tag, "_res"}, {res_valid, res_addr, res_data}, 64'd0);
    chk({tag, "_flags"}, {busy, frame_done}, 64'd0);
    chk({tag, "_fsad"}, 64'(frame_sad), 64'd0);
  endtask

  // stub ME core
  initial begin
    int st, cnt;
    st = 0; cnt = 0;
    me_done = 0; me_mv_x = 0; me_mv_y = 0; me_sad = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        me_done = 0;
        st = 0;
      end else begin
        case (st)
          0: if (me_start && !me_done && st_k < NMB) begin
            cnt = dlys[st_k];
            st = 1;
          end
          1: if (cnt <= 1) begin
            me_done = 1;
            me_mv_x = 6'(mvx[st_k]);
            me_mv_y = 6'(mvy[st_k]);
            me_sad  = 16'(sads[st_k]);
            st_k++;
            st = 2;
          end else cnt--;
          2: if (!me_start) begin
            if (hold_cyc == 0) begin
              me_done = 0;
              st = 0;
            end else begin
              cnt = hold_cyc;
              st = 3;
            end
          end
          default: begin
            cnt--;
            if (cnt <= 0) begin
              me_done = 0;
              st = 0;
            end
          end
        endcase
      end
    end
  end

  // result buffer ready
  initial begin
    res_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && res_valid && wr_cnt == 4) begin
        res_ready = 0;
        stall_left--;
      end else begin
        res_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    bit          prev_start, prev_fd, held;
    logic [8:0]  h_addr;
    logic [31:0] h_data;
    prev_start = 0; prev_fd = 0; held = 0;
    h_addr = 0; h_data = 0;
    fd_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_start = 0; prev_fd = 0; held = 0;
      end else begin
        if (me_start && !prev_start) begin
          chk("no_double_trigger", 64'(me_done), 64'd0);
          chk("mb_x", 64'(me_mb_x), 64'((edge_cnt % MX) * 16));
          chk("mb_y", 64'(me_mb_y), 64'((edge_cnt / MX) * 16));
          chk("frame_addr", 64'(me_frame_addr), 64'(exp_cur));
          chk("ref_addr", 64'(me_ref_addr), 64'(exp_ref));
          edge_cnt++;
        end
        if (res_valid) begin
          chk("start_held_in_write", 64'(me_start), 64'd1);
          if (held) begin
            chk("stable_addr", 64'(res_addr), 64'(h_addr));
            chk("stable_data", 64'(res_data), 64'(h_data));
          end
          if (res_ready) begin
            if (exp_addr.size() == 0) begin
              chk("unexpected_write", 64'd1, 64'd0);
            end else begin
              chk("res_addr", 64'(res_addr), 64'(exp_addr.pop_front()));
              chk("res_data", 64'(res_data), 64'(exp_data.pop_front()));
            end
            wr_cnt++;
            held = 0;
          end else begin
            held = 1;
            h_addr = res_addr;
            h_data = res_data;
          end
        end
        if (frame_done) begin
          chk("frame_done_pulse", 64'(prev_fd), 64'd0);
          chk("writes_left", 64'(exp_addr.size()), 64'd0);
          chk("frame_sad", 64'(frame_sad), 64'(exp_fsad));
          chk("busy_at_done", 64'(busy), 64'd1);
          fd_cnt++;
        end
        prev_start = me_start;
        prev_fd = frame_done;
      end
    end
  end

  initial begin
    rst_n = 0; frame_go = 0; cur_base = 0; ref_base = 0;
    rnd_ready = 0; stall_left = 0; hold_cyc = 0;
    exp_cur = 0; exp_ref = 0; exp_fsad = 0;
    wr_cnt = 0; edge_cnt = 0; st_k = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_check("reset");
    @(posedge clk); #1;
    rst_n = 1;

    setup_frame(0, 5, 0, 0);
    stall_left = 7;
    go();
    wait_fd(20000);
    idle_check();

    setup_frame(1, 0, 3, 1);
    go();
    wait_fd(20000);
    idle_check();

    setup_frame(0, 0, 1, 1);
    go();
    wait_wr(20, 5000);
    @(posedge clk); #1;
    cur_base = 32'hDEAD_0000;
    ref_base = 32'hBEEF_0000;
    frame_go = 1;
    @(posedge clk); #1;
    frame_go = 0;
    wait_wr(100, 10000);
    rst_n = 0;
    @(negedge clk);
    reset_check("midframe_reset");
    setup_frame(0, 0, 3, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    go();
    wait_fd(20000);
    idle_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
